// File: rtl/produto_escalar_pkg.sv
// Shared types and widths for the dot-product engine and its arbiter.
package produto_escalar_pkg;

    localparam int unsigned VEC_LEN = 8;
    localparam int unsigned ELEM_W  = 32;
    localparam int unsigned RES_W   = 64;

    typedef logic signed [ELEM_W-1:0]         elem_t;
    typedef logic signed [RES_W-1:0]          result_t;
    typedef logic [VEC_LEN*ELEM_W-1:0]        vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/produto_escalar_arb_if.sv
// Requester and engine signals seen by the arbiter. The arbiter uses the slave
// view; the requesters plus the engine together form the master side.
interface produto_escalar_arb_if #(
    parameter int unsigned N_REQ = 4
);
    import produto_escalar_pkg::*;

    // Requester side
    logic [N_REQ-1:0]                req;
    logic [N_REQ*VEC_LEN*ELEM_W-1:0] req_a;
    logic [N_REQ*VEC_LEN*ELEM_W-1:0] req_b;
    logic [N_REQ-1:0]                gnt;
    logic [N_REQ-1:0]                rsp_valid;
    logic [N_REQ-1:0]                rsp_ready;
    result_t                         rsp_result;
    logic                            rsp_err;

    // Engine side
    logic                            eng_start;
    vec_t                            eng_a;
    vec_t                            eng_b;
    logic                            eng_done;
    result_t                         eng_result;

    logic                            busy;

    modport slave (
        input  req, req_a, req_b, rsp_ready, eng_done, eng_result,
        output gnt, rsp_valid, rsp_result, rsp_err, eng_start, eng_a, eng_b, busy
    );

    modport master (
        output req, req_a, req_b, rsp_ready, eng_done, eng_result,
        input  gnt, rsp_valid, rsp_result, rsp_err, eng_start, eng_a, eng_b, busy
    );

endinterface

// File: rtl/produto_escalar_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module produto_escalar_arb_rr_pick #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        int unsigned       cand;
        logic [IDX_W-1:0]  cand_idx;
        valid    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = int'(N_REQ); off >= 1; off--) begin
            cand     = (int'(last) + off) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/produto_escalar_arb.sv
// Round-robin owner of a single produto_escalar engine shared by N_REQ
// requesters: grant, issue, wait for done (with watchdog), respond.
module produto_escalar_arb
    import produto_escalar_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    produto_escalar_arb_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned VEC_W = VEC_LEN * ELEM_W;

    typedef logic [IDX_W-1:0] idx_t;

    arb_state_t       state_q, state_d;
    idx_t             g_q, g_d;
    idx_t             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    result_t          res_q, res_d;
    logic             err_q, err_d;

    logic             pick_valid;
    idx_t             pick_idx;
    logic [N_REQ-1:0] g_onehot;
    vec_t             a_vec [N_REQ];
    vec_t             b_vec [N_REQ];

    produto_escalar_arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign a_vec[i] = bus.req_a[i*VEC_W +: VEC_W];
        assign b_vec[i] = bus.req_b[i*VEC_W +: VEC_W];
    end

    // State register; reset abandons any in-flight operation without a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= idx_t'(N_REQ - 1);
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Next-state: done is only looked at in WAIT, and beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    g_d     = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.eng_done) begin
                    res_d   = bus.eng_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready[g_q]) begin
                    last_d  = g_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-hot view of the current owner.
    always_comb begin
        g_onehot       = '0;
        g_onehot[g_q]  = 1'b1;
    end

    assign bus.gnt        = (state_q != IDLE) ? g_onehot : '0;
    assign bus.rsp_valid  = (state_q == RESP) ? g_onehot : '0;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;
    assign bus.eng_start  = (state_q == ISSUE);
    assign bus.eng_a      = a_vec[g_q];
    assign bus.eng_b      = b_vec[g_q];
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_produto_escalar_arb.sv
// Bench for produto_escalar_arb: directed scenarios plus a randomized phase,
// checked against a round-robin / dot-product reference model.
module tb_produto_escalar_arb;
    import produto_escalar_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 32;
    localparam int unsigned VW = VEC_LEN * ELEM_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    produto_escalar_arb_if #(.N_REQ(N)) bus ();

    produto_escalar_arb #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stimulus state
    int          av [N][VEC_LEN];
    int          bv [N][VEC_LEN];
    logic [N-1:0] reqv   = '0;
    logic [N-1:0] readyv = '0;
    int          eng_lat    = 8;
    logic        late_pulse = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_req
        for (genvar k = 0; k < VEC_LEN; k++) begin : g_elem
            assign bus.req_a[(i*VEC_LEN+k)*ELEM_W +: ELEM_W] = av[i][k];
            assign bus.req_b[(i*VEC_LEN+k)*ELEM_W +: ELEM_W] = bv[i][k];
        end
    end
    assign bus.req       = reqv;
    assign bus.rsp_ready = readyv;

    // Engine stub: latches vectors on start, raises done eng_lat cycles later
    // (done lands in cycle eng_lat+2 counting the grant cycle as 0); 0 = never.
    function automatic logic [63:0] eng_dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint s = 0;
        for (int k = 0; k < int'(VEC_LEN); k++)
            s += longint'($signed(a[k*ELEM_W +: ELEM_W])) * longint'($signed(b[k*ELEM_W +: ELEM_W]));
        return s;
    endfunction

    int          stub_cnt  = 0;
    logic        stub_done = 1'b0;
    logic [63:0] stub_res  = '0;
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (bus.eng_start) begin
            stub_res <= eng_dot(bus.eng_a, bus.eng_b);
            stub_cnt <= eng_lat;
        end else if (stub_cnt != 0) begin
            if (stub_cnt == 1) stub_done <= 1'b1;
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign bus.eng_done   = stub_done | late_pulse;
    assign bus.eng_result = stub_res;

    int cyc     = 0;
    int n_start = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.eng_start) n_start <= n_start + 1;

    // Reference model
    int last_m = N - 1;

    function automatic int rr_model(input logic [N-1:0] m, input int last);
        for (int off = 1; off <= int'(N); off++)
            if (m[(last + off) % N]) return (last + off) % N;
        return -1;
    endfunction

    function automatic logic [63:0] dot_model(input int r);
        longint s = 0;
        for (int k = 0; k < int'(VEC_LEN); k++) s += longint'(av[r][k]) * longint'(bv[r][k]);
        return s;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rand_vec(input int r);
        for (int k = 0; k < int'(VEC_LEN); k++) begin
            av[r][k] = $urandom;
            bv[r][k] = $urandom;
        end
    endtask

    // Wait (bounded) for a response and check owner, result, error and latency.
    task automatic expect_resp(input string tag, input int owner, input logic [63:0] res,
                               input logic err, input int t0, input int lat);
        logic [N-1:0] oh;
        int waited;
        oh = '0;
        if (owner >= 0) oh[owner] = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.rsp_valid == '0 && waited < 200);
        check_eq({tag, "_valid"}, 64'(bus.rsp_valid), 64'(oh));
        check_eq({tag, "_gnt"}, 64'(bus.gnt), 64'(oh));
        check_eq({tag, "_result"}, bus.rsp_result, res);
        check_eq({tag, "_err"}, 64'(bus.rsp_err), 64'(err));
        if (lat >= 0) check_eq({tag, "_lat"}, 64'(cyc - t0), 64'(lat));
    endtask

    task automatic handshake(input int owner, input bit drop);
        @(posedge clk); #1;
        readyv = '0;
        readyv[owner] = 1'b1;
        @(posedge clk); #1;
        readyv = '0;
        if (drop) reqv[owner] = 1'b0;
        last_m = owner;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        reqv  = '0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        last_m = N - 1;
    endtask

    int lat_tab [7] = '{0, 1, 3, 8, 12, 31, 32};

    initial begin
        int t0, s0, owner, lat_now;
        logic ok;
        logic [N-1:0] oh, newbits;

        for (int i = 0; i < int'(N); i++) rand_vec(i);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_gnt", 64'(bus.gnt), 64'(0));
        check_eq("rst_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("rst_result", bus.rsp_result, 64'(0));
        check_eq("rst_err", 64'(bus.rsp_err), 64'(0));
        check_eq("rst_start", 64'(bus.eng_start), 64'(0));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));

        // Single requester 1: a=1..8, b=2 -> 72, response in cycle 11
        for (int k = 0; k < int'(VEC_LEN); k++) begin
            av[1][k] = k + 1;
            bv[1][k] = 2;
        end
        eng_lat = 8;
        @(posedge clk); #1;
        reqv[1] = 1'b1;
        t0 = cyc;
        s0 = n_start;
        @(negedge clk);
        check_eq("t1_idle_gnt", 64'(bus.gnt), 64'(0));
        @(negedge clk);
        check_eq("t1_issue_gnt", 64'(bus.gnt), 64'(4'b0010));
        check_eq("t1_issue_start", 64'(bus.eng_start), 64'(1));
        check_eq("t1_issue_busy", 64'(bus.busy), 64'(1));
        expect_resp("t1", rr_model(reqv, last_m), 64'd72, 1'b0, t0, 11);
        check_eq("t1_nstart", 64'(n_start - s0), 64'(1));
        handshake(1, 1);

        // All requesters pending from reset, ready tied high: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(VEC_LEN); k++) begin
                av[i][k] = 0;
                bv[i][k] = 0;
            end
        av[0][0] = -3;
        bv[0][0] = 5;
        reqv   = '1;
        readyv = '1;
        for (int n = 0; n < 5; n++) begin
            owner = rr_model(reqv, last_m);
            expect_resp($sformatf("t2_op%0d", n), owner, dot_model(owner), 1'b0, 0, -1);
            last_m = owner;
        end
        check_eq("t2_neg15", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFF1);
        @(posedge clk); #1;
        reqv   = '0;
        readyv = '0;
        @(posedge clk); #1;

        // Backpressure on requester 2 while requester 0 waits
        rand_vec(0);
        rand_vec(2);
        reqv = 4'b0101;
        owner = rr_model(reqv, last_m);
        expect_resp("t3", owner, dot_model(owner), 1'b0, 0, -1);
        s0 = n_start;
        oh = '0;
        oh[owner] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", 64'(bus.rsp_valid), 64'(oh));
            check_eq("t3_hold_result", bus.rsp_result, dot_model(owner));
        end
        check_eq("t3_no_start", 64'(n_start - s0), 64'(0));
        handshake(owner, 1);
        owner = rr_model(reqv, last_m);
        expect_resp("t3_next", owner, dot_model(owner), 1'b0, 0, -1);
        handshake(owner, 1);

        // Engine never finishes: timeout after 32 WAIT cycles; late done ignored
        eng_lat = 0;
        rand_vec(1);
        reqv[1] = 1'b1;
        t0 = cyc;
        expect_resp("t4_to", 1, 64'(0), 1'b1, t0, 2 + int'(TO));
        @(posedge clk); #1 late_pulse = 1'b1;
        @(posedge clk); #1 late_pulse = 1'b0;
        @(negedge clk);
        check_eq("t4_late_err", 64'(bus.rsp_err), 64'(1));
        check_eq("t4_late_result", bus.rsp_result, 64'(0));
        check_eq("t4_late_valid", 64'(bus.rsp_valid), 64'(4'b0010));
        handshake(1, 1);
        eng_lat = 8;
        rand_vec(1);
        reqv[1] = 1'b1;
        t0 = cyc;
        expect_resp("t4_after", 1, dot_model(1), 1'b0, t0, 11);
        handshake(1, 1);

        // Reset during WAIT, then requester 3
        reqv[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        reqv  = '0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        last_m = N - 1;
        @(negedge clk);
        check_eq("t5_gnt", 64'(bus.gnt), 64'(0));
        check_eq("t5_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("t5_busy", 64'(bus.busy), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        rand_vec(3);
        reqv[3] = 1'b1;
        t0 = cyc;
        expect_resp("t5_r3", rr_model(reqv, last_m), dot_model(3), 1'b0, t0, 11);
        handshake(3, 1);

        // Done coincides with the last WAIT cycle: done wins
        eng_lat = int'(TO) - 1;
        rand_vec(2);
        reqv[2] = 1'b1;
        t0 = cyc;
        expect_resp("t6", 2, dot_model(2), 1'b0, t0, 2 + int'(TO));
        handshake(2, 1);

        // Randomized traffic against the model
        reqv = 4'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < int'(N); i++) rand_vec(i);
        eng_lat = lat_tab[$urandom_range(6)];
        for (int n = 0; n < 40; n++) begin
            owner   = rr_model(reqv, last_m);
            lat_now = eng_lat;
            ok      = (lat_now >= 1) && (lat_now <= int'(TO) - 1);
            expect_resp($sformatf("rnd%0d", n), owner, ok ? dot_model(owner) : 64'(0), !ok, 0, -1);
            oh = '0;
            oh[owner] = 1'b1;
            for (int s = 0; s < int'($urandom_range(3)); s++) begin
                @(posedge clk); #1;
                readyv = 4'($urandom) & ~oh;
                @(negedge clk);
                check_eq($sformatf("rnd%0d_hold", n), 64'(bus.rsp_valid), 64'(oh));
            end
            @(posedge clk); #1;
            readyv = 4'($urandom) | oh;
            @(posedge clk); #1;
            readyv = '0;
            if ($urandom_range(1) == 1) reqv[owner] = 1'b0;
            newbits = 4'($urandom);
            for (int i = 0; i < int'(N); i++)
                if (!reqv[i] && newbits[i]) begin
                    rand_vec(i);
                    reqv[i] = 1'b1;
                end
            if (reqv == '0) begin
                rand_vec((owner + 1) % N);
                reqv[(owner + 1) % N] = 1'b1;
            end
            eng_lat = lat_tab[$urandom_range(6)];
            last_m  = owner;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/produto_escalar_arb.md
Name: produto_escalar_arb

Overview:
- Round-robin controller that shares one `produto_escalar` engine among N_REQ requesters.
- Per operation it selects a requester and muxes that requester's a/b vectors onto the engine inputs. It then pulses the engine start, waits for done (bounded by a watchdog) and returns the 64-bit result to the owning requester over a valid/ready response.
- Sits between SoC-side CSR/requester ports and the single engine instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 32, max cycles in WAIT before the operation is aborted with an error.
- VEC_LEN, 8, elements per vector; fixed to the engine width, taken from the package.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  N_REQ  request per requester; held high until that requester's response handshake completes.
- req_a  in  N_REQ*VEC_LEN*32  vector a per requester; element k of requester i at bits [(i*VEC_LEN+k)*32 +: 32].
- req_b  in  N_REQ*VEC_LEN*32  vector b, same layout as req_a.
- gnt  out  N_REQ  one-hot owner of the engine; all zero in IDLE.
- rsp_valid  out  N_REQ  one-hot response valid.
- rsp_ready  in  N_REQ  response accept per requester.
- rsp_result  out  64  signed result, shared by all requesters; qualified by rsp_valid.
- rsp_err  out  1  high with rsp_valid when the operation timed out; rsp_result is 0 in that case.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a  out  VEC_LEN*32  muxed a vector to the engine (a0 at bits [31:0]).
- eng_b  out  VEC_LEN*32  muxed b vector to the engine.
- eng_done  in  1  engine done.
- eng_result  in  64  engine result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state=IDLE, gnt=0, rsp_valid=0, rsp_result=0, rsp_err=0, eng_start=0, busy=0.
  - Timeout counter = 0; round-robin pointer last=N_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-operation abandons the operation: no response is issued and the engine is left to finish on its own.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If |req, pick the first set bit scanning last+1, last+2, … modulo N_REQ.
  - Register the pick as g, set gnt one-hot, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - eng_start=1.
  - eng_a/eng_b = requester g's slices; they are combinational muxes on g and valid in every non-IDLE state. The engine latches them at this edge.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - eng_done=1: register rsp_result=eng_result, rsp_err=0, go to RESP.
  - Else the counter increments; when the counter equals TIMEOUT-1 and eng_done=0: rsp_result=0, rsp_err=1, go to RESP.
  - If eng_done and the timeout coincide, done wins.
- RESP:
  - rsp_valid[g]=1, with rsp_result and rsp_err stable.
  - On rsp_ready[g]=1: rsp_valid drops next cycle, gnt clears, last=g, return to IDLE.
  - rsp_ready of other requesters is ignored.
- Engine done is ignored outside WAIT (stale or late done after a timeout has no effect).
- eng_start is never asserted outside ISSUE; at most one operation is in flight.
- req deasserted by the owner before its response: the operation still completes and the response is still presented. A requester that drops req is not re-granted until it raises req again.
- Latency with the engine: req high in IDLE at cycle 0 → ISSUE at cycle 1 → eng_done at cycle 10 → rsp_valid at cycle 11. The next grant comes no earlier than 1 cycle after the response handshake.
- Fairness: with all requests held continuously, grants rotate 0,1,…,N_REQ-1,0,… with no repeats.

Decomposition:
- Package produto_escalar_pkg:
  - VEC_LEN=8, ELEM_W=32, RES_W=64.
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT, RESP}.
  - Element/result typedefs.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N_REQ], last index.
  - Outputs: valid, index.
  - Instantiated once; the top level holds the FSM, timeout counter and muxes.

Test Plan:
- Single requester 1: a=1..8, b=all 2 → gnt=4'b0010, one eng_start pulse, rsp_valid[1] at cycle 11, rsp_result=72, rsp_err=0.
- All four req high from reset, rsp_ready tied high → grant order 0,1,2,3,0. Requester 0 with a0=-3, b0=5, rest 0 → rsp_result=-15 (0xFFFF_FFFF_FFFF_FFF1).
- Backpressure: requester 2 holds rsp_ready=0 for 5 cycles → rsp_valid/rsp_result stable, no new eng_start, req[0] stays pending until after the handshake.
- Engine stub that never asserts done, TIMEOUT=32 → rsp_valid with rsp_err=1, rsp_result=0 after 32 WAIT cycles. A late done pulse afterwards is ignored; the next request completes normally.
- rst_n low for 1 cycle during WAIT → next cycle gnt=0, rsp_valid=0, busy=0, state IDLE. A subsequent request from requester 3 is granted and returns the correct result.
- Coincident eng_done and timeout (stub done exactly at cycle TIMEOUT) → rsp_err=0 and the stub's result is returned.
